pipeline_catch_buffer: RTL and testbench



---
 rtl/pipeline_catch_buffer.sv | 167 ++++++++++++++++
 tb/tb_pipeline_catch_buffer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_catch_buffer.sv
// -----------------------------------------------------------------------------
// pipeline_catch_buffer
//
// Catch buffer placed directly behind a fixed-latency pipeline that cannot
// stall. Issue slots into the pipeline are granted against a credit counter,
// one credit per FIFO entry, so every result that eventually leaves the
// pipeline already has a reserved slot. Results are held in a circular FIFO
// and presented downstream on a valid/ready interface.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// valid never depends on ready; once m_valid is high it stays high with
// m_data stable until the beat is taken.
//
// Parameters:
//   Width : payload width
//   Depth : FIFO entries and issue credits (>= 1, any value)
//   CntW  : derived counter width, not overridable
//
// Ports:
//   clk          : clock, all state updates on the rising edge
//   rst          : synchronous active-high reset
//   s_valid      : producer wants to issue an item into the pipeline
//   s_ready      : issue granted (a credit is available)
//   pipe_valid   : pipeline output qualifier
//   pipe_data    : pipeline output data
//   m_valid      : downstream data available
//   m_ready      : downstream accepts
//   m_data       : head-of-FIFO data (0 while empty)
//   credits      : free credits
//   overflow_err : sticky, a pipeline beat arrived with the FIFO full
//
// Optional feature (macro PIPELINE_CATCH_BUFFER_BYPASS_EN):
//   When defined and the FIFO is empty, a pipe_valid beat is forwarded to
//   m_valid/m_data combinationally. If it is accepted in the same cycle it is
//   never written. When undefined, results always spend one cycle in the FIFO.
// -----------------------------------------------------------------------------
module pipeline_catch_buffer #(
    parameter  int Width = 8,
    parameter  int Depth = 4,
    localparam int CntW  = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             pipe_valid,
    input  logic [Width-1:0] pipe_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [Width-1:0] m_data,
    output logic [CntW-1:0]  credits,
    output logic             overflow_err
);

    localparam int              PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [Width-1:0] storage [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  count;
    logic [CntW-1:0]  credit_cnt;
    logic             overflow_q;

    // -------------------------------------------------------------------------
    // Combinational control
    // -------------------------------------------------------------------------
    logic fifo_empty;
    logic fifo_full;
    logic bypass;       // beat is presented straight from pipe_* this cycle
    logic bypass_take;  // bypassed beat is consumed without touching storage
    logic issue;
    logic pop;          // downstream transfer, including a bypassed one
    logic fifo_pop;     // transfer that removes the FIFO head
    logic fifo_write;
    logic drop;

    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == DepthCnt);

`ifdef PIPELINE_CATCH_BUFFER_BYPASS_EN
        bypass = fifo_empty && pipe_valid;
`else
        bypass = 1'b0;
`endif

        s_ready = (credit_cnt != '0);
        issue   = s_valid && s_ready;

        m_valid = !fifo_empty || bypass;
        if (bypass) begin
            m_data = pipe_data;
        end else if (fifo_empty) begin
            // Storage is never reset, so hide it while nothing is queued.
            m_data = '0;
        end else begin
            m_data = storage[rd_ptr];
        end

        pop         = m_valid && m_ready;
        fifo_pop    = pop && !fifo_empty;
        bypass_take = bypass && m_ready;

        // A full FIFO still accepts a beat when its head leaves in the same
        // cycle; otherwise the beat has nowhere to go and is dropped.
        fifo_write = pipe_valid && !bypass_take && (!fifo_full || fifo_pop);
        drop       = pipe_valid && fifo_full && !fifo_pop;

        credits      = credit_cnt;
        overflow_err = overflow_q;
    end

    // -------------------------------------------------------------------------
    // Storage (contents intentionally not reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (fifo_write) begin
            storage[wr_ptr] <= pipe_data;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers, occupancy, credits, error flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            credit_cnt <= DepthCnt;
            overflow_q <= 1'b0;
        end else begin
            // Explicit wrap because Depth need not be a power of two.
            if (fifo_write) begin
                wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + PtrW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + PtrW'(1);
            end

            if (fifo_write && !fifo_pop) begin
                count <= count + CntW'(1);
            end else if (fifo_pop && !fifo_write) begin
                count <= count - CntW'(1);
            end

            // issue implies credit_cnt != 0, so the decrement cannot wrap.
            // The increment is clamped so a producer that ignores s_ready
            // cannot push the counter above Depth.
            if (issue && !pop) begin
                credit_cnt <= credit_cnt - CntW'(1);
            end else if (pop && !issue && (credit_cnt != DepthCnt)) begin
                credit_cnt <= credit_cnt + CntW'(1);
            end

            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_catch_buffer.sv
// -----------------------------------------------------------------------------
// Bench for pipeline_catch_buffer (Width=8, Depth=4).
// Inputs change 1 time unit after each rising edge; outputs are checked on
// the falling edge against a queue-based reference model that is then
// advanced by the rules of the block (credits = bounded issue/pop balance,
// FIFO = ordered queue of at most Depth entries, sticky overflow).
// -----------------------------------------------------------------------------
module tb_pipeline_catch_buffer;

    localparam int Width = 8;
    localparam int Depth = 4;
    localparam int CntW  = $clog2(Depth + 1);

    logic             clk;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic             pipe_valid;
    logic [Width-1:0] pipe_data;
    logic             m_valid;
    logic             m_ready;
    logic [Width-1:0] m_data;
    logic [CntW-1:0]  credits;
    logic             overflow_err;

    pipeline_catch_buffer #(.Width(Width), .Depth(Depth)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .pipe_valid   (pipe_valid),
        .pipe_data    (pipe_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .credits      (credits),
        .overflow_err (overflow_err)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- counters and reference model ----------------
    int total = 0;
    int bad   = 0;

    logic [Width-1:0] exp_q[$];
    int               model_credits;
    bit               model_ovf;

    int dut_issues;
    int min_credits;

    // 2-stage pipeline delay line feeding pipe_valid/pipe_data
    bit               sr_v [2];
    logic [Width-1:0] sr_d [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        s_valid    = 1'b0;
        pipe_valid = 1'b0;
        pipe_data  = '0;
        m_ready    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_credits = Depth;
        model_ovf     = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sr_v[i] = 1'b0;
            sr_d[i] = '0;
        end
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_credits", 32'(credits), 32'(Depth));
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_overflow_err", 32'(overflow_err), 32'd0);
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic cycle(input bit sv, input bit pv, input logic [Width-1:0] pd,
                         input bit mr, output bit issued);
        bit               byp;
        bit               exp_sr;
        bit               exp_mv;
        bit               pop;
        logic [Width-1:0] exp_md;

        s_valid    = sv;
        pipe_valid = pv;
        pipe_data  = pd;
        m_ready    = mr;
        @(negedge clk);

        byp = 1'b0;
`ifdef PIPELINE_CATCH_BUFFER_BYPASS_EN
        byp = (exp_q.size() == 0) && pv;
`endif
        exp_sr = (model_credits != 0);
        exp_mv = (exp_q.size() != 0) || byp;
        exp_md = byp ? pd : ((exp_q.size() != 0) ? exp_q[0] : '0);

        check("credits", 32'(credits), 32'(model_credits));
        check("s_ready", 32'(s_ready), 32'(exp_sr));
        check("m_valid", 32'(m_valid), 32'(exp_mv));
        if (exp_mv) check("m_data", 32'(m_data), 32'(exp_md));
        check("overflow_err", 32'(overflow_err), 32'(model_ovf));

        if (sv && s_ready) dut_issues++;
        if (credits < min_credits) min_credits = credits;

        issued = sv && exp_sr;
        pop    = exp_mv && mr;
        if (!(byp && mr)) begin
            if (pop) void'(exp_q.pop_front());
            if (pv) begin
                if (exp_q.size() < Depth) exp_q.push_back(pd);
                else model_ovf = 1'b1;
            end
        end
        model_credits = model_credits - int'(issued) + int'(pop);
        if (model_credits > Depth) model_credits = Depth;

        @(posedge clk);
        #1;
    endtask

    task automatic pipe_cycle(input bit sv, input logic [Width-1:0] id_data,
                              input bit mr, output bit issued);
        cycle(sv, sr_v[1], sr_d[1], mr, issued);
        sr_v[1] = sr_v[0];
        sr_d[1] = sr_d[0];
        sr_v[0] = issued;
        sr_d[0] = id_data;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        bit iss;
        int next_id;
        logic [Width-1:0] din;

        min_credits = Depth;
        dut_issues  = 0;

        // 1: six issue requests with no downstream pops -> exactly Depth issues
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b0, iss);
        check("step1_issue_count", 32'(dut_issues), 32'(Depth));

        // 2: four results queued, then drained in order
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'hA1 + 8'(i), 1'b0, iss);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, 1'b1, iss);

        // 3: steady state, 20 items through a 2-cycle pipeline
        do_reset();
        min_credits = Depth;
        next_id = 0;
        for (int i = 0; i < 40; i++) begin
            pipe_cycle(next_id < 20, 8'(next_id), 1'b1, iss);
            if (iss) next_id++;
        end
        check("step3_issued", 32'(next_id), 32'd20);
        check("step3_min_credits_nonzero", 32'(min_credits != 0), 32'd1);

        // randomized traffic with an honest producer
        do_reset();
        for (int i = 0; i < 300; i++) begin
            din = 8'($urandom_range(0, 255));
            pipe_cycle($urandom_range(0, 1) == 1, din, $urandom_range(0, 3) != 0, iss);
        end
        for (int i = 0; i < 8; i++) pipe_cycle(1'b0, '0, 1'b1, iss);

        // 4: full FIFO, write and pop together
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, 1'b0, iss);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'hB1 + 8'(i), 1'b0, iss);
        cycle(1'b0, 1'b1, 8'hB5, 1'b1, iss);

        // 5: full FIFO, beat with no pop is dropped; error is sticky
        cycle(1'b0, 1'b1, 8'hEE, 1'b0, iss);
        cycle(1'b0, 1'b0, '0, 1'b0, iss);
        cycle(1'b0, 1'b0, '0, 1'b0, iss);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, 1'b1, iss);
        check("step5_overflow_held", 32'(overflow_err), 32'd1);

        // 6: reset mid-operation
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0, iss);
        cycle(1'b0, 1'b1, 8'hC1, 1'b0, iss);
        cycle(1'b0, 1'b1, 8'hC2, 1'b0, iss);
        do_reset();

        // empty FIFO with a beat and downstream ready (bypass when enabled)
        cycle(1'b0, 1'b1, 8'h5C, 1'b1, iss);
        cycle(1'b0, 1'b0, '0, 1'b1, iss);
        cycle(1'b0, 1'b0, '0, 1'b1, iss);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
